// File: rtl/intr_resp_ctrl.sv
// intr_resp_ctrl: interrupt/overflow responder that flushes the pipeline, redirects fetch to the handler and restores the PC on iret
module intr_resp_ctrl #(
    parameter int          N_IRQ        = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             interrupt_en,
    input  logic [N_IRQ-1:0] irq,
    input  logic             over_flow,
    input  logic [31:0]      ex_pc,
    input  logic             iret,
    output logic             pipe_flush,
    output logic             pc_sel,
    output logic [31:0]      target_pc,
    output logic [31:0]      epc,
    output logic [4:0]       cause,
    output logic             in_handler,
    output logic [N_IRQ-1:0] irq_ack
);
    localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, FLUSH, ENTER, SERVICE, RETURN} state_t;
    state_t           state, state_n;
    logic [N_IRQ-1:0] irq_q, pending, edges;
    logic             armed, take, take_irq, is_irq;
    logic [2:0]       sel, idx;
    logic [CW-1:0]    cnt;
    // armed masks the first cycle after reset, so a line already high is not mistaken for a new edge
    assign edges    = irq & ~irq_q & {N_IRQ{armed}};
    assign take_irq = interrupt_en & |pending;
    assign take     = (state == IDLE) & (over_flow | take_irq);
    // lowest pending index wins
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (pending[i]) sel = 3'(i);
    end
    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? FLUSH : IDLE;
            FLUSH:   state_n = (cnt == '0) ? ENTER : FLUSH;
            ENTER:   state_n = SERVICE;
            SERVICE: state_n = iret ? RETURN : SERVICE;
            RETURN:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // edge capture; a new edge wins over the acknowledge clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            armed   <= 1'b0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            armed   <= 1'b1;
            pending <= (pending & ~irq_ack) | edges;
        end
    end
    // take bookkeeping: return PC, cause, serviced line and flush countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            epc    <= '0;
            cause  <= '0;
            is_irq <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
        end else if (take) begin
            epc    <= ex_pc;
            cause  <= over_flow ? 5'h0C : {2'b10, sel};
            is_irq <= ~over_flow;
            idx    <= sel;
            cnt    <= CW'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
    // outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_flush <= 1'b0;
            pc_sel     <= 1'b0;
            target_pc  <= '0;
            in_handler <= 1'b0;
            irq_ack    <= '0;
        end else begin
            pipe_flush <= state_n inside {FLUSH, ENTER, RETURN};
            pc_sel     <= state_n inside {ENTER, RETURN};
            target_pc  <= (state_n == ENTER) ? HANDLER_ADDR : (state_n == RETURN) ? epc : 32'h0;
            in_handler <= state_n inside {SERVICE, RETURN};
            irq_ack    <= (state_n == ENTER && is_irq) ? N_IRQ'(1) << idx : '0;
        end
    end
endmodule

// File: tb/tb_intr_resp_ctrl.sv
// tb_intr_resp_ctrl: directed self-checking bench for intr_resp_ctrl
module tb_intr_resp_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        interrupt_en = 1'b0;
    logic [3:0]  irq = '0;
    logic        over_flow = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        iret = 1'b0;
    logic        pipe_flush, pc_sel, in_handler;
    logic [31:0] target_pc, epc;
    logic [4:0]  cause;
    logic [3:0]  irq_ack;
    int checks = 0;
    int errors = 0;

    intr_resp_ctrl dut (
        .clk(clk), .rst_n(rst_n), .interrupt_en(interrupt_en), .irq(irq),
        .over_flow(over_flow), .ex_pc(ex_pc), .iret(iret),
        .pipe_flush(pipe_flush), .pc_sel(pc_sel), .target_pc(target_pc),
        .epc(epc), .cause(cause), .in_handler(in_handler), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic f, input logic p, input logic [31:0] t,
                           input logic h, input logic [3:0] a);
        chk({tag, ".pipe_flush"}, 32'(pipe_flush), 32'(f));
        chk({tag, ".pc_sel"},     32'(pc_sel),     32'(p));
        chk({tag, ".target_pc"},  target_pc,       t);
        chk({tag, ".in_handler"}, 32'(in_handler), 32'(h));
        chk({tag, ".irq_ack"},    32'(irq_ack),    32'(a));
    endtask

    // called right after the take edge; walks FLUSH, FLUSH, ENTER and lands in SERVICE
    task automatic entry(input string tag, input logic [31:0] e_epc, input logic [4:0] e_cause,
                         input logic [3:0] e_ack);
        chk_out({tag, ".flush1"}, 1, 0, 32'h0, 0, 4'h0);
        tick();
        chk_out({tag, ".flush2"}, 1, 0, 32'h0, 0, 4'h0);
        tick();
        chk_out({tag, ".enter"}, 1, 1, 32'h40, 0, e_ack);
        chk({tag, ".epc"},   epc,          e_epc);
        chk({tag, ".cause"}, 32'(cause),   32'(e_cause));
        tick();
        chk_out({tag, ".service"}, 0, 0, 32'h0, 1, 4'h0);
    endtask

    task automatic ret(input string tag, input logic [31:0] e_tgt);
        iret = 1'b1;
        tick();
        iret = 1'b0;
        chk_out({tag, ".return"}, 1, 1, e_tgt, 1, 4'h0);
        tick();
        chk_out({tag, ".idle"}, 0, 0, 32'h0, 0, 4'h0);
    endtask

    initial begin
        tick();
        chk_out("reset", 0, 0, 32'h0, 0, 4'h0);
        chk("reset.epc", epc, 32'h0);
        chk("reset.cause", 32'(cause), 32'h0);
        rst_n = 1'b1;
        tick();
        // reset mid-FLUSH, then irq held high must not retrigger
        interrupt_en = 1'b1;
        ex_pc = 32'h80;
        irq = 4'b0100;
        tick();
        tick();
        chk("t1.inflush", 32'(pipe_flush), 32'h1);
        rst_n = 1'b0;
        #1;
        chk_out("t1.abort", 0, 0, 32'h0, 0, 4'h0);
        chk("t1.abort.epc", epc, 32'h0);
        chk("t1.abort.cause", 32'(cause), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_out("t1.noretake", 0, 0, 32'h0, 0, 4'h0);
        irq = 4'b0000;
        tick();
        // IRQ2 entry and return
        irq = 4'b0100;
        ex_pc = 32'h100;
        tick();
        chk("t2.nottaken_yet", 32'(pipe_flush), 32'h0);
        tick();
        entry("t2", 32'h100, 5'h12, 4'b0100);
        ret("t2", 32'h100);
        irq = 4'b0000;
        // overflow beats a simultaneous IRQ0 edge; IRQ0 follows in first IDLE cycle
        over_flow = 1'b1;
        irq = 4'b0001;
        ex_pc = 32'h200;
        tick();
        over_flow = 1'b0;
        ex_pc = 32'h999;
        entry("t3.ovf", 32'h200, 5'h0C, 4'b0000);
        ret("t3.ovf", 32'h200);
        chk("t3.epc_hold", epc, 32'h200);
        ex_pc = 32'h204;
        tick();
        entry("t3.irq0", 32'h204, 5'h10, 4'b0001);
        ret("t3.irq0", 32'h204);
        irq = 4'b0000;
        // masked requests stay pending; lowest index first
        interrupt_en = 1'b0;
        tick();
        irq = 4'b1010;
        tick();
        tick();
        tick();
        chk_out("t4.masked", 0, 0, 32'h0, 0, 4'h0);
        interrupt_en = 1'b1;
        ex_pc = 32'h300;
        tick();
        entry("t4.irq1", 32'h300, 5'h11, 4'b0010);
        ret("t4.irq1", 32'h300);
        ex_pc = 32'h310;
        tick();
        entry("t4.irq3", 32'h310, 5'h13, 4'b1000);
        // nesting: overflow ignored, new IRQ1 edge latched in SERVICE
        irq = 4'b1000;
        tick();
        irq = 4'b1010;
        tick();
        over_flow = 1'b1;
        ex_pc = 32'h777;
        tick();
        over_flow = 1'b0;
        chk_out("t6.still_service", 0, 0, 32'h0, 1, 4'h0);
        chk("t6.epc", epc, 32'h310);
        chk("t6.cause", 32'(cause), 32'h13);
        ret("t6", 32'h310);
        ex_pc = 32'h320;
        tick();
        entry("t6.irq1", 32'h320, 5'h11, 4'b0010);
        ret("t6.irq1", 32'h320);
        irq = 4'b0000;
        // stray iret in IDLE, then return to 0x3C4
        iret = 1'b1;
        tick();
        iret = 1'b0;
        chk_out("t5.stray", 0, 0, 32'h0, 0, 4'h0);
        tick();
        chk_out("t5.stray2", 0, 0, 32'h0, 0, 4'h0);
        over_flow = 1'b1;
        ex_pc = 32'h3C4;
        tick();
        over_flow = 1'b0;
        entry("t5", 32'h3C4, 5'h0C, 4'b0000);
        ret("t5", 32'h3C4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
